// File: rtl/inst_issue_stage.sv
// inst_issue_stage: scoreboarded single-issue stage between the instruction queue and execute
module inst_issue_stage #(
  parameter int PayloadLen = 32,
  parameter int EntryW     = PayloadLen + 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [EntryW-1:0] q_rdata_i,
  input  logic              q_valid_i,
  output logic              used_o,
  output logic [EntryW-1:0] ex_data_o,
  output logic              ex_valid_o,
  input  logic              ex_allowin_i,
  input  logic              wb_we_i,
  input  logic [4:0]        wb_addr_i,
  input  logic              flush_i,
  output logic [31:0]       stall_cnt_o
);
  logic [4:0] rd, rj, rk;
  logic rd_we, rj_use, rk_use, hz, out_ready, fire;
  logic ex_valid_q, ex_valid_d;
  logic [EntryW-1:0] ex_data_q, ex_data_d;
  logic [31:0] pend_q, pend_d, stall_cnt_q, stall_cnt_d;
  assign rd     = q_rdata_i[4:0];
  assign rj     = q_rdata_i[9:5];
  assign rk     = q_rdata_i[14:10];
  assign rd_we  = q_rdata_i[15];
  assign rj_use = q_rdata_i[16];
  assign rk_use = q_rdata_i[17];
  always_comb begin
    hz          = (rj_use & pend_q[rj]) | (rk_use & pend_q[rk]) | (rd_we & pend_q[rd]);
    out_ready   = !ex_valid_q | ex_allowin_i;
    fire        = q_valid_i & !hz & out_ready & !flush_i;
    ex_valid_d  = flush_i ? 1'b0 : out_ready ? fire : ex_valid_q;
    ex_data_d   = fire ? q_rdata_i : ex_data_q;
    // later assignments win: issue-set overrides writeback-clear, flush overrides both
    pend_d = pend_q;
    if (wb_we_i) pend_d[wb_addr_i] = 1'b0;
    if (fire & rd_we) pend_d[rd] = 1'b1;
    if (flush_i) pend_d = '0;
    pend_d[0]   = 1'b0;
    stall_cnt_d = (q_valid_i & hz & !flush_i & ~&stall_cnt_q) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_data_q   <= '0;
      pend_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_data_q   <= ex_data_d;
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign used_o      = fire;
  assign ex_valid_o  = ex_valid_q;
  assign ex_data_o   = ex_data_q;
  assign stall_cnt_o = stall_cnt_q;
endmodule
